// File: rtl/wb_timer_responder.sv
// 8-bit Wishbone classic responder exposing a 16-bit free-running timer as a register file.
// Latency: o_Ack one cycle after the strobe is sampled; writes, read data and read side effects all land on that edge.
// Backpressure: none; a strobe held high is acked every second cycle, and each ack is exactly one access.
module wb_timer_responder #(
  parameter logic [15:0] DEFAULT_TOP  = 16'hFFFF,
  parameter logic        RESET_ENABLE = 1'b1,
  parameter logic        RESET_IRQ_EN = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       i_Cyc,
  input  logic       i_Stb,
  input  logic       i_We,
  input  logic [7:0] i_Adr,
  input  logic [7:0] i_Dat,
  output logic [7:0] o_Dat,
  output logic       o_Ack,
  output logic       o_Int,
  output logic       o_Wrap
);

  localparam logic [7:0] ADR_CTRL = 8'h5E;
  localparam logic [7:0] ADR_TOP0 = 8'h60;
  localparam logic [7:0] ADR_TOP1 = 8'h61;
  localparam logic [7:0] ADR_CNT0 = 8'h65;
  localparam logic [7:0] ADR_CNT1 = 8'h66;
  localparam logic [7:0] ADR_STAT = 8'h6A;

  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;
  logic [15:0] count_q, count_d;
  logic [15:0] top_q, top_d;
  logic [7:0]  top_lo_buf_q, top_lo_buf_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_flag_q, ovf_flag_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        shadow_valid_q, shadow_valid_d;

  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic        clr;
  logic        wrap;
  logic [7:0]  rd_dat;

  // Read mux: reflects register state before this edge's update, so counter reads are live.
  always_comb begin
    rd_dat = 8'h00;
    case (i_Adr)
      ADR_CTRL: rd_dat = {5'b00000, irq_en_q, 1'b0, en_q};
      ADR_TOP0: rd_dat = top_q[7:0];
      ADR_TOP1: rd_dat = top_q[15:8];
      ADR_CNT0: rd_dat = count_q[7:0];
      ADR_CNT1: rd_dat = shadow_valid_q ? shadow_q : count_q[15:8];
      ADR_STAT: rd_dat = {7'b0000000, ovf_flag_q};
      default:  rd_dat = 8'h00;
    endcase
  end

  // Next-state: bus handshake, register writes, read side effects and counter (clear > wrap > increment).
  always_comb begin
    ack_d          = ack_q;
    dat_d          = dat_q;
    count_d        = count_q;
    top_d          = top_q;
    top_lo_buf_d   = top_lo_buf_q;
    en_d           = en_q;
    irq_en_d       = irq_en_q;
    ovf_flag_d     = ovf_flag_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    clr            = 1'b0;

    // A strobe still high on the ack cycle is not re-accepted.
    access = i_Cyc & i_Stb & ~ack_q;
    wr_acc = access & i_We;
    rd_acc = access & ~i_We;
    wrap   = en_q & (count_q >= top_q);

    ack_d = access;

    if (rd_acc) begin
      dat_d = rd_dat;
      if (i_Adr == ADR_CNT0) begin
        // Latch the high byte so a following CNT1 read is coherent with this low byte.
        shadow_d       = count_q[15:8];
        shadow_valid_d = 1'b1;
      end else if ((i_Adr == ADR_CNT1) && shadow_valid_q) begin
        shadow_valid_d = 1'b0;
      end
    end

    if (wr_acc) begin
      case (i_Adr)
        ADR_CTRL: begin
          en_d     = i_Dat[0];
          clr      = i_Dat[1];
          irq_en_d = i_Dat[2];
        end
        ADR_TOP0: top_lo_buf_d = i_Dat;
        // Both bytes of top change together so the compare never sees a half-written value.
        ADR_TOP1: top_d = {i_Dat, top_lo_buf_q};
        ADR_STAT: if (i_Dat[0]) ovf_flag_d = 1'b0;
        default:  ;
      endcase
    end

    // A wrap on the same edge as a flag clear leaves the flag set.
    if (wrap) ovf_flag_d = 1'b1;

    if (clr) begin
      count_d = 16'h0000;
    end else if (wrap) begin
      count_d = 16'h0000;
    end else if (en_q) begin
      count_d = count_q + 16'd1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ack_q          <= 1'b0;
      dat_q          <= 8'h00;
      count_q        <= 16'h0000;
      top_q          <= DEFAULT_TOP;
      top_lo_buf_q   <= DEFAULT_TOP[7:0];
      en_q           <= RESET_ENABLE;
      irq_en_q       <= RESET_IRQ_EN;
      ovf_flag_q     <= 1'b0;
      shadow_q       <= 8'h00;
      shadow_valid_q <= 1'b0;
    end else begin
      ack_q          <= ack_d;
      dat_q          <= dat_d;
      count_q        <= count_d;
      top_q          <= top_d;
      top_lo_buf_q   <= top_lo_buf_d;
      en_q           <= en_d;
      irq_en_q       <= irq_en_d;
      ovf_flag_q     <= ovf_flag_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign o_Ack  = ack_q;
  assign o_Dat  = dat_q;
  assign o_Int  = ovf_flag_q & irq_en_q;
  // Gated by Reset so a DEFAULT_TOP of zero cannot pulse while held in reset.
  assign o_Wrap = wrap & ~Reset;

endmodule

// File: tb/tb_wb_timer_responder.sv
module tb_wb_timer_responder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       i_Cyc = 1'b0;
  logic       i_Stb = 1'b0;
  logic       i_We  = 1'b0;
  logic [7:0] i_Adr = 8'h00;
  logic [7:0] i_Dat = 8'h00;
  logic [7:0] o_Dat;
  logic       o_Ack;
  logic       o_Int;
  logic       o_Wrap;

  int checks = 0;
  int errors = 0;

  wb_timer_responder dut (
    .Clock (Clock),
    .Reset (Reset),
    .i_Cyc (i_Cyc),
    .i_Stb (i_Stb),
    .i_We  (i_We),
    .i_Adr (i_Adr),
    .i_Dat (i_Dat),
    .o_Dat (o_Dat),
    .o_Ack (o_Ack),
    .o_Int (o_Int),
    .o_Wrap(o_Wrap)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One single-strobe access; the access edge is the first posedge after the call.
  task automatic bus(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                     output logic [7:0] rdat);
    @(negedge Clock);
    i_Cyc = 1'b1; i_Stb = 1'b1; i_We = we; i_Adr = adr; i_Dat = wdat;
    #1 check("ack_before_edge", {15'd0, o_Ack}, 16'd0);
    @(posedge Clock);
    #1 check("ack_rise", {15'd0, o_Ack}, 16'd1);
    rdat = o_Dat;
    @(negedge Clock);
    i_Cyc = 1'b0; i_Stb = 1'b0; i_We = 1'b0;
    @(posedge Clock);
    #1 check("ack_fall", {15'd0, o_Ack}, 16'd0);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [7:0] wdat);
    logic [7:0] unused_rd;
    bus(1'b1, adr, wdat, unused_rd);
  endtask

  task automatic rd(input string tag, input logic [7:0] adr, input logic [7:0] exp);
    logic [7:0] d;
    bus(1'b0, adr, 8'h00, d);
    check(tag, {8'd0, d}, {8'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
  endtask

  initial begin
    int acks;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_ack", {15'd0, o_Ack}, 16'd0);
    check("rst_dat", {8'd0, o_Dat}, 16'd0);
    check("rst_int", {15'd0, o_Int}, 16'd0);
    check("rst_wrap", {15'd0, o_Wrap}, 16'd0);
    Reset = 1'b0;

    // Counting from release: CNT1 at count 0, then at count 512
    rd("cnt1_at_0", 8'h66, 8'h00);
    idle(510);
    rd("cnt1_at_512", 8'h66, 8'h02);
    rd("ctrl_rst", 8'h5E, 8'h01);
    rd("top0_rst", 8'h60, 8'hFF);
    rd("top1_rst", 8'h61, 8'hFF);
    rd("stat_rst", 8'h6A, 8'h00);
    rd("unmapped", 8'h20, 8'h00);

    // TOP0 alone does not change top
    wr(8'h60, 8'h05);
    rd("top0_buffered", 8'h60, 8'hFF);
    wr(8'h5E, 8'h03);
    idle(10);
    rd("cnt0_past_5", 8'h65, 8'h0B);
    rd("stat_no_wrap", 8'h6A, 8'h00);
    wr(8'h61, 8'h00);
    rd("top0_loaded", 8'h60, 8'h05);
    rd("top1_loaded", 8'h61, 8'h00);
    rd("stat_wrap5", 8'h6A, 8'h01);

    // TOP = 9: period of 10, wrap while count == 9
    wr(8'h60, 8'h09);
    wr(8'h61, 8'h00);
    wr(8'h5E, 8'h03);
    for (int i = 0; i < 30; i++) begin
      @(posedge Clock);
      #1 check("wrap_period", {15'd0, o_Wrap}, {15'd0, (i % 10) == 7});
    end
    rd("cnt0_mod10", 8'h65, 8'h01);
    rd("stat_set", 8'h6A, 8'h01);
    wr(8'h5E, 8'h04);
    check("int_on", {15'd0, o_Int}, 16'd1);
    wr(8'h6A, 8'h01);
    check("int_off", {15'd0, o_Int}, 16'd0);
    rd("stat_cleared", 8'h6A, 8'h00);
    rd("cnt0_frozen_a", 8'h65, 8'h06);
    idle(100);
    rd("cnt0_frozen_b", 8'h65, 8'h06);
    check("wrap_frozen", {15'd0, o_Wrap}, 16'd0);

    // TOP = 0: wraps every cycle; a flag clear coinciding with a wrap loses
    wr(8'h60, 8'h00);
    wr(8'h61, 8'h00);
    wr(8'h5E, 8'h05);
    check("wrap_top0", {15'd0, o_Wrap}, 16'd1);
    check("int_top0", {15'd0, o_Int}, 16'd1);
    rd("cnt0_top0", 8'h65, 8'h00);
    wr(8'h6A, 8'h01);
    rd("stat_set_wins", 8'h6A, 8'h01);
    check("int_set_wins", {15'd0, o_Int}, 16'd1);

    // Lowering top below count 0x0100 wraps on the next cycle
    wr(8'h60, 8'hFF);
    wr(8'h61, 8'hFF);
    wr(8'h6A, 8'h01);
    wr(8'h5E, 8'h03);
    wr(8'h60, 8'h10);
    rd("stat_pre_lower", 8'h6A, 8'h00);
    idle(251);
    wr(8'h61, 8'h00);
    rd("cnt0_after_lower", 8'h65, 8'h00);
    rd("stat_after_lower", 8'h6A, 8'h01);

    // Shadowed high byte across 0x12FF -> 0x1300
    wr(8'h60, 8'hFF);
    wr(8'h61, 8'hFF);
    wr(8'h6A, 8'h01);
    wr(8'h5E, 8'h03);
    idle(4862);
    rd("cnt0_12ff", 8'h65, 8'hFF);
    rd("cnt1_shadow", 8'h66, 8'h12);
    rd("cnt1_live", 8'h66, 8'h13);

    // Clear at count 0x4000
    idle(11515);
    wr(8'h5E, 8'h03);
    rd("cnt0_after_clr", 8'h65, 8'h01);
    rd("cnt1_after_clr", 8'h66, 8'h00);
    rd("ctrl_clr_reads0", 8'h5E, 8'h01);

    // Strobe held for six cycles: three acks
    @(negedge Clock);
    i_Cyc = 1'b1; i_Stb = 1'b1; i_We = 1'b0; i_Adr = 8'h20;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock);
      #1 if (o_Ack) acks++;
    end
    check("held_acks", 16'(acks), 16'd3);
    check("held_unmapped_dat", {8'd0, o_Dat}, 16'd0);
    @(negedge Clock);
    i_Cyc = 1'b0; i_Stb = 1'b0;
    @(posedge Clock);

    // Reset during an ack
    wr(8'h60, 8'h00);
    wr(8'h61, 8'h00);
    wr(8'h5E, 8'h05);
    check("int_pre_reset", {15'd0, o_Int}, 16'd1);
    @(negedge Clock);
    i_Cyc = 1'b1; i_Stb = 1'b1; i_We = 1'b0; i_Adr = 8'h5E;
    @(posedge Clock);
    #1;
    check("ack_pre_reset", {15'd0, o_Ack}, 16'd1);
    check("dat_pre_reset", {8'd0, o_Dat}, 16'h0005);
    Reset = 1'b1;
    #1;
    check("ack_in_reset", {15'd0, o_Ack}, 16'd0);
    check("dat_in_reset", {8'd0, o_Dat}, 16'd0);
    check("int_in_reset", {15'd0, o_Int}, 16'd0);
    check("wrap_in_reset", {15'd0, o_Wrap}, 16'd0);
    i_Cyc = 1'b0; i_Stb = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    rd("ctrl_after_rst", 8'h5E, 8'h01);
    rd("top0_after_rst", 8'h60, 8'hFF);
    rd("top1_after_rst", 8'h61, 8'hFF);
    rd("stat_after_rst", 8'h6A, 8'h00);
    wr(8'h61, 8'hAB);
    rd("lobuf_after_rst", 8'h60, 8'hFF);
    rd("top1_ab", 8'h61, 8'hAB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_timer_responder.md
Name: wb_timer_responder

Overview:
- 8-bit Wishbone classic responder that presents a 16-bit free-running timer/counter as a small register file.
- Gives our FPGA designs a portable timer peripheral that any on-chip Wishbone master can poll. The existing LED colour poller reads it at address 0x66 unchanged.
- Also provides a wrap pulse and a maskable interrupt for local logic.

Parameters:
- DEFAULT_TOP, 16'hFFFF, counter top value loaded at reset.
- RESET_ENABLE, 1, value of the counter-enable bit after reset (1 = counting immediately).
- RESET_IRQ_EN, 0, value of the interrupt-enable bit after reset.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- i_Cyc  input  1  Wishbone bus cycle.
- i_Stb  input  1  Wishbone strobe.
- i_We  input  1  1 = write, 0 = read.
- i_Adr  input  8  register address.
- i_Dat  input  8  write data.
- o_Dat  output  8  read data; valid while o_Ack = 1.
- o_Ack  output  1  single-cycle acknowledge.
- o_Int  output  1  level interrupt = ovf_flag & irq_en.
- o_Wrap  output  1  one-cycle pulse when the counter wraps TOP -> 0.

Behaviour:
- Reset values:
  - o_Dat = 0, o_Ack = 0, o_Int = 0, o_Wrap = 0.
  - count = 0, top = DEFAULT_TOP, top_lo_buf = DEFAULT_TOP[7:0].
  - en = RESET_ENABLE, irq_en = RESET_IRQ_EN.
  - ovf_flag = 0, shadow = 0, shadow_valid = 0.
- Handshake:
  - o_Ack <= i_Cyc & i_Stb & ~o_Ack (registered).
  - Ack rises exactly 1 cycle after a strobe is first sampled and lasts 1 cycle.
  - If the strobe is still high on the ack cycle, it is not re-acked that cycle. A strobe held high is therefore acked every second cycle.
  - Each acked strobe = exactly one access.
- Access timing:
  - Writes commit on the same edge that raises o_Ack.
  - Read data is registered onto o_Dat on that edge and held until the next ack.
  - Read side effects also occur on that edge.
  - Unmapped addresses: read 0x00, writes ignored, still acked.
- Register map:
  - 0x5E CTRL (rw):
    - bit0 en, bit2 irq_en.
    - bit1 clear: write-1 sets count to 0 on the following cycle; always reads 0.
    - Other bits read 0.
  - 0x60 TOP0 (rw): write goes to top_lo_buf only; read returns top[7:0].
  - 0x61 TOP1 (rw): write loads top <= {i_Dat, top_lo_buf} atomically; read returns top[15:8].
  - 0x65 CNT0 (r): returns count[7:0]; same edge captures shadow <= count[15:8] and sets shadow_valid.
  - 0x66 CNT1 (r): returns shadow and clears shadow_valid if shadow_valid = 1; otherwise returns live count[15:8].
  - 0x6A STAT (rw): bit0 ovf_flag; write 1 to bit0 clears it; writes of 0 have no effect.
- Counter, evaluated each Clock:
  - Priority: clear > wrap > increment.
  - If en: when count >= top, count <= 0, o_Wrap = 1 for that cycle, ovf_flag <= 1; else count <= count + 1.
  - Using >= means lowering top below the current count wraps on the next cycle.
  - top = 0 → count stays at 0 and wraps every cycle.
  - If en = 0, count holds; o_Wrap = 0.
- Simultaneous events:
  - Wrap on the same edge as a STAT clear-write → flag stays 1 (set wins).
  - Clear on the same cycle as a wrap → count = 0, and wrap/flag still take effect.
- Reads are live: the CNT0 value is the count before that edge's update.
- Reset mid-access: o_Ack drops immediately; the access is lost; the master must retry.

Test Plan:
- Reset release, RESET_ENABLE = 1 → read 0x66 returns 0x00; after 512 cycles a read of 0x66 returns 0x02; every ack is exactly 1 cycle wide, 1 cycle after the strobe.
- Write TOP0 = 0x09, then TOP1 = 0x00 → count sequence 0..9,0; o_Wrap pulses every 10 cycles; STAT reads 0x01; write STAT = 0x01 → reads 0x00; with irq_en = 1, o_Int tracks the flag.
- Counter at 0x12FF: read CNT0 → 0xFF/0x00 with shadow = 0x12; after it passes 0x1300, CNT1 returns 0x12; a second CNT1 read returns the live value 0x13.
- Write TOP0 = 0x05 only → top unchanged (0xFFFF, counter passes 0x0005 without wrapping); then TOP1 = 0x00 → top = 0x0005.
- With count = 0x0100, write TOP = 0x0010 → wrap on the next cycle, flag set.
- Hold stb/cyc high for 6 cycles → exactly 3 acks; unmapped address 0x20 reads 0x00.
- Write CTRL = 0x03 with count = 0x4000 → count = 0 next cycle; CTRL reads 0x01.
- Write en = 0 → count frozen across 100 cycles.
- Assert Reset during an ack → o_Ack = 0 immediately and all registers return to reset values.
